inject_fifo_ni: RTL and testbench
=================================

# inject_fifo_ni

Network-interface injection buffer that sits directly downstream of a per-node traffic source. The source streams 20-bit flits with a one-cycle valid strobe and cannot be back-pressured. This block captures those flits into a circular FIFO and presents them to the router's local input port over a valid/ready handshake. It also counts accepted and dropped flits and raises a sticky overflow flag so hotspot experiments can measure injection loss.

## Interface
Parameters:
- WIDTH, 20, flit width in bits.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- AW, 3, pointer width; equals log2(DEPTH).
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  flit from the upstream source.
- in_valid  in  1  in_data is valid this cycle; single-cycle strobe with no ready return.
- out_data  out  WIDTH  head-of-FIFO flit to the router.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  router accepts out_data this cycle.
- fifo_count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  fifo_count == DEPTH.
- empty  out  1  fifo_count == 0.
- accept_cnt  out  CNT_W  flits written into the FIFO; saturating.
- drop_cnt  out  CNT_W  flits discarded because there was no room; saturating.
- overflow  out  1  sticky; set on the first drop.

## Operation
- Storage is a DEPTH x WIDTH register array with wr_ptr and rd_ptr, each AW bits.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - Occupancy is held in a separate AW+1-bit counter.
- Signal definitions:
  - pop = out_valid & out_ready.
  - push_ok = in_valid & (!full | pop).
  - drop = in_valid & !push_ok.
- push_ok:
  - mem[wr_ptr] <= in_data.
  - wr_ptr increments.
  - accept_cnt increments, saturating at all-ones.
- pop: rd_ptr increments.
- Occupancy update:
  - fifo_count += push_ok - pop.
  - Simultaneous push_ok and pop leaves the count unchanged.
- Full with a simultaneous pop: the push is accepted. The write goes to the slot being vacated (wr_ptr == rd_ptr); this is legal because the read is combinational from the old contents.
- Empty with in_valid: the flit is written and becomes visible the next cycle. There is no same-cycle bypass, and pop cannot occur while empty.
- Drop:
  - The flit is discarded and memory and pointers are unchanged.
  - drop_cnt increments, saturating.
  - overflow <= 1 and holds until reset.
- Output is first-word-fall-through:
  - out_data = mem[rd_ptr] (combinational).
  - out_valid = !empty.
  - out_data is don't-care while empty; the bench must not check it.
- out_valid/out_data stay stable while out_ready is low (standard valid/ready hold).
- Ordering is strictly FIFO. No reordering, no flit modification.
- Counter saturation freezes only that counter; FIFO operation continues.

## Timing
- Reset values (rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, fifo_count=0.
  - empty=1, full=0, out_valid=0.
  - accept_cnt=0, drop_cnt=0, overflow=0.
  - Memory contents are not reset.
- Reset mid-operation: all buffered flits are lost immediately, outputs take their reset values asynchronously, and operation resumes on the first rising edge after rst deasserts.
- Write latency: a flit sampled at edge N appears on out_data with out_valid=1 after edge N, when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained. With out_ready held high, an uninterrupted source stream sees zero drops.
- full/empty/fifo_count/overflow are registered or derived from registered state only; no combinational path from in_valid.
- No combinational path from in_valid/in_data to any output. out_valid does not depend on out_ready.

## Test plan
- Stream 30 flits 0x03010, 0x03020, ..., 0x031E0 on consecutive cycles with out_ready=1 -> 30 pops in order, each one cycle after its push. Final accept_cnt=30, drop_cnt=0, overflow=0, empty=1.
- Same 30-flit stream with out_ready=0 -> accept_cnt=8 and drop_cnt=22, with full=1 from the cycle after the 8th flit and overflow=1. Then raise out_ready -> drains 0x03010..0x03080 in order, then empty=1.
- Fill to full, then in one cycle assert in_valid with 0xABCDE and out_ready=1 -> push accepted, fifo_count stays 8, drop_cnt unchanged. 0xABCDE emerges 8th on the subsequent drain.
- Wrap-around: alternate pushes and 2-cycle-delayed pops for 20 flits with DEPTH=8 -> pointers wrap at least twice, output order exact, count never exceeds 3.
- Assert rst asynchronously (between clock edges) with fifo_count=5 and overflow=1 -> all outputs go to reset values before the next edge. The next push after release appears as the sole entry.
- CNT_W=4: with out_ready=0 and DEPTH=8, inject 30 flits -> accept_cnt=8, drop_cnt saturates at 15, overflow=1.

Source files
------------

// File: rtl/inject_fifo_ni.sv
// Injection buffer between a non-stallable flit source and a router local port.
// Circular FIFO with first-word-fall-through output, plus accept/drop statistics.
module inject_fifo_ni #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      fifo_count,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);

    localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign full       = (count_q == FULL_COUNT);
    assign empty      = (count_q == '0);
    assign fifo_count = count_q;
    assign out_valid  = !empty;
    assign out_data   = mem[rd_ptr];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign pop     = out_valid & out_ready;
    assign push_ok = in_valid & (!full | pop);
    assign drop    = in_valid & !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok && accept_cnt != CNT_MAX) begin
                accept_cnt <= accept_cnt + 1'b1;
            end
            if (drop && drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inject_fifo_ni.sv
// Directed bench for inject_fifo_ni; a second instance with 4-bit counters
// shares the stimulus so counter saturation can be observed.
module tb_inject_fifo_ni;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic [19:0] out_data;
    logic        out_valid;
    logic [3:0]  fifo_count;
    logic        full;
    logic        empty;
    logic [7:0]  accept_cnt;
    logic [7:0]  drop_cnt;
    logic        overflow;

    logic [19:0] out_data4;
    logic        out_valid4;
    logic [3:0]  fifo_count4;
    logic        full4;
    logic        empty4;
    logic [3:0]  accept_cnt4;
    logic [3:0]  drop_cnt4;
    logic        overflow4;

    int n_cmp = 0;
    int n_err = 0;
    logic [19:0] q[$];

    always #5 clk = ~clk;

    inject_fifo_ni #(.WIDTH(20), .DEPTH(8), .AW(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .full(full), .empty(empty),
        .accept_cnt(accept_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    inject_fifo_ni #(.WIDTH(20), .DEPTH(8), .AW(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .fifo_count(fifo_count4), .full(full4), .empty(empty4),
        .accept_cnt(accept_cnt4), .drop_cnt(drop_cnt4), .overflow(overflow4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives one cycle, checks the head if it pops.
    task automatic cycle(input logic v, input logic [19:0] d, input logic r);
        logic do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        do_pop = r && (q.size() != 0);
        if (do_pop) begin
            check("out_data", {12'd0, out_data}, {12'd0, q[0]});
            void'(q.pop_front());
        end
        if (v && q.size() < 8) begin
            q.push_back(d);
        end
        @(posedge clk);
        #1;
        check("fifo_count", {28'd0, fifo_count}, q.size());
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        q.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #2;
        check("rst_count", {28'd0, fifo_count}, 0);
        check("rst_empty", {31'd0, empty}, 1);
        check("rst_full", {31'd0, full}, 0);
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_acc", {24'd0, accept_cnt}, 0);
        check("rst_drop", {24'd0, drop_cnt}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with the router always ready.
        for (int i = 0; i < 30; i++) cycle(1'b1, 20'h03000 + 20'(16 * (i + 1)), 1'b1);
        cycle(1'b0, 20'h0, 1'b1);
        check("t1_acc", {24'd0, accept_cnt}, 30);
        check("t1_drop", {24'd0, drop_cnt}, 0);
        check("t1_ovf", {31'd0, overflow}, 0);
        check("t1_empty", {31'd0, empty}, 1);

        // Router stalled: 8 accepted, 22 dropped.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 20'h03000 + 20'(16 * (i + 1)), 1'b0);
            if (i == 6) check("t2_notfull", {31'd0, full}, 0);
            if (i == 7) check("t2_full", {31'd0, full}, 1);
        end
        check("t2_acc", {24'd0, accept_cnt}, 8);
        check("t2_drop", {24'd0, drop_cnt}, 22);
        check("t2_ovf", {31'd0, overflow}, 1);
        check("t2_acc4", {28'd0, accept_cnt4}, 8);
        check("t2_drop4", {28'd0, drop_cnt4}, 15);
        check("t2_ovf4", {31'd0, overflow4}, 1);
        check("t2_head", {12'd0, out_data}, 32'h03010);
        for (int i = 0; i < 8; i++) cycle(1'b0, 20'h0, 1'b1);
        check("t2_empty", {31'd0, empty}, 1);
        check("t2_ovf_sticky", {31'd0, overflow}, 1);

        // Push into a full FIFO while the head pops.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 20'h0A000 + 20'(i), 1'b0);
        check("t3_full", {31'd0, full}, 1);
        cycle(1'b1, 20'hABCDE, 1'b1);
        check("t3_count", {28'd0, fifo_count}, 8);
        check("t3_drop", {24'd0, drop_cnt}, 0);
        check("t3_acc", {24'd0, accept_cnt}, 9);
        for (int i = 0; i < 6; i++) cycle(1'b0, 20'h0, 1'b1);
        check("t3_last_old", {12'd0, out_data}, 32'h0A007);
        cycle(1'b0, 20'h0, 1'b1);
        check("t3_abcde", {12'd0, out_data}, 32'hABCDE);
        cycle(1'b0, 20'h0, 1'b1);
        check("t3_empty", {31'd0, empty}, 1);

        // Wrap-around: pops trail pushes by two cycles.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 20'h0C000 + 20'(i * 3), i >= 2);
            check("t4_cnt_le3", {31'd0, fifo_count <= 4'd3}, 1);
        end
        cycle(1'b0, 20'h0, 1'b1);
        cycle(1'b0, 20'h0, 1'b1);
        check("t4_empty", {31'd0, empty}, 1);
        check("t4_acc", {24'd0, accept_cnt}, 20);

        // Asynchronous reset mid-operation.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 20'h0B000 + 20'(i), 1'b0);
        cycle(1'b1, 20'h0BFFF, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 20'h0, 1'b1);
        check("t5_pre_count", {28'd0, fifo_count}, 5);
        check("t5_pre_ovf", {31'd0, overflow}, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        #2;
        check("t5_count", {28'd0, fifo_count}, 0);
        check("t5_empty", {31'd0, empty}, 1);
        check("t5_full", {31'd0, full}, 0);
        check("t5_valid", {31'd0, out_valid}, 0);
        check("t5_ovf", {31'd0, overflow}, 0);
        check("t5_acc", {24'd0, accept_cnt}, 0);
        check("t5_drop", {24'd0, drop_cnt}, 0);
        rst = 1'b0;
        q.delete();
        cycle(1'b1, 20'h55555, 1'b0);
        check("t5_one", {28'd0, fifo_count}, 1);
        check("t5_one_valid", {31'd0, out_valid}, 1);
        check("t5_one_data", {12'd0, out_data}, 32'h55555);
        cycle(1'b0, 20'h0, 1'b1);
        check("t5_end_empty", {31'd0, empty}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
